reg_b: RTL and testbench

//   Load-enabled 16-bit holding register, "register B", for the controller datapath.

---
 rtl/reg_b_pkg.sv | 13 +
 rtl/reg_b.sv | 36 +++
 tb/tb_reg_b.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_b_pkg.sv
// Shared datapath constants for the controller's holding registers.
// Sibling registers (A, B, ...) take their default width and reset word
// from here so the datapath stays consistent in one place.
package reg_b_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0] dataWord_t;

    // Reset word for register B.
    localparam dataWord_t REG_B_RESET = 16'h0000;

endpackage : reg_b_pkg

// File: rtl/reg_b.sv
// reg_b: load-enabled holding register "B" for the controller datapath.
// Captures dataBin on a rising clk edge when loadB is high, otherwise holds.
// The stored word drives dataBout directly from the flops.
//
// Parameters:
//   WIDTH      data width in bits (default DATA_W from reg_b_pkg)
//   RESET_VAL  word forced by reset (default REG_B_RESET from reg_b_pkg)
// Ports:
//   clk       in   1      single clock, rising-edge
//   rst_n     in   1      asynchronous active-low reset
//   loadB     in   1      load enable, 1 = capture dataBin at next edge
//   dataBin   in   WIDTH  data to be stored
//   dataBout  out  WIDTH  registered contents
module reg_b
    import reg_b_pkg::*;
#(
    parameter int unsigned          WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0]     RESET_VAL = WIDTH'(REG_B_RESET)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loadB,
    input  logic [WIDTH-1:0] dataBin,
    output logic [WIDTH-1:0] dataBout
);

    // An unknown loadB does not satisfy the if, so the register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataBout <= RESET_VAL;
        end else if (loadB) begin
            dataBout <= dataBin;
        end
    end

endmodule : reg_b

// File: tb/tb_reg_b.sv
module tb_reg_b;

    localparam int unsigned W = 16;
    localparam logic [W-1:0] RST = 16'h0000;

    logic         clk;
    logic         rst_n;
    logic         loadB;
    logic [W-1:0] dataBin;
    logic [W-1:0] dataBout;

    int unsigned nCompared   = 0;
    int unsigned nMismatched = 0;

    // Reference: the value the register is supposed to hold right now.
    logic [W-1:0] refVal;

    reg_b #(
        .WIDTH     (W),
        .RESET_VAL (RST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .loadB    (loadB),
        .dataBin  (dataBin),
        .dataBout (dataBout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after an edge, wait for the next edge,
    // update the reference from the rules, compare 1 time unit after the edge.
    task automatic cycle(input string tag, input logic ld, input logic [W-1:0] d);
        loadB   = ld;
        dataBin = d;
        @(posedge clk);
        #1;
        if (!rst_n)  refVal = RST;
        else if (ld) refVal = d;
        checkVal(tag, dataBout, refVal);
    endtask

    // Same as cycle, but dataBin is disturbed mid-cycle and restored before the edge.
    task automatic glitchCycle(input string tag, input logic ld, input logic [W-1:0] d,
                               input logic [W-1:0] glitch);
        loadB   = ld;
        dataBin = d;
        #2 dataBin = glitch;
        #1 checkVal({tag, "_mid"}, dataBout, refVal);
        #1 dataBin = d;
        @(posedge clk);
        #1;
        if (!rst_n)  refVal = RST;
        else if (ld) refVal = d;
        checkVal(tag, dataBout, refVal);
    endtask

    // Asynchronous reset pulse placed between edges; checks the immediate clear.
    task automatic midReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        refVal = RST;
        checkVal(tag, dataBout, refVal);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        loadB   = 1'b0;
        dataBin = '0;
        refVal  = RST;

        // Power-on reset, asserted before any clock edge.
        #1 rst_n = 1'b0;
        #1 checkVal("por", dataBout, RST);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Put a nonzero word in, then reset asynchronously mid-cycle.
        cycle("preload", 1'b1, 16'hBEEF);
        #2 rst_n = 1'b0;
        #1 refVal = RST;
        checkVal("async_clear", dataBout, refVal);
        // Reset held over two edges with a load pending.
        cycle("rst_hold0", 1'b1, 16'hFFFF);
        cycle("rst_hold1", 1'b1, 16'hFFFF);
        rst_n = 1'b1;

        // First capture after release.
        cycle("first_load", 1'b1, 16'h00FE);
        // Hold with changing data.
        cycle("hold0", 1'b0, 16'h0FE6);
        cycle("hold1", 1'b0, 16'h0FE6);
        cycle("load_0fe6", 1'b1, 16'h0FE6);
        // Continuous load tracking.
        cycle("track0", 1'b1, 16'h1234);
        cycle("track1", 1'b1, 16'hABCD);
        cycle("track2", 1'b1, 16'hFFFF);

        // Reset mid-cycle while loading 5A5A; no capture while held.
        loadB   = 1'b1;
        dataBin = 16'h5A5A;
        #2 rst_n = 1'b0;
        #1 refVal = RST;
        checkVal("rst_vs_load", dataBout, refVal);
        cycle("rst_vs_load_edge", 1'b1, 16'h5A5A);
        rst_n = 1'b1;
        cycle("after_rst_load", 1'b1, 16'h5A5A);

        // Glitches between edges.
        glitchCycle("glitch_hold", 1'b0, 16'h1111, 16'hEEEE);
        glitchCycle("glitch_load", 1'b1, 16'h2222, 16'hDDDD);

        // Bit mapping: walking one across the word.
        for (int i = 0; i < int'(W); i++) begin
            cycle("walk1", 1'b1, 16'(1) << i);
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            logic          ld;
            logic [W-1:0]  d;
            ld = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                loadB   = ld;
                dataBin = d;
                midReset("rand_async");
            end
            if ($urandom_range(0, 9) == 0)
                glitchCycle("rand_glitch", ld, d, 16'($urandom));
            else
                cycle("rand", ld, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_reg_b
